// File: rtl/diff_fifo_rd_port.sv
// Read side of a FIFO: pulls whole RAM words and serialises them as OUT_WIDTH slices, LS slice first.
// Optional level counter enabled by defining DIFF_FIFO_RD_LEVEL_EN.
module diff_fifo_rd_port #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [ADDR_WIDTH:0]                           wr_ptr,
  output logic [ADDR_WIDTH-1:0]                         ram_addr_b,
  input  logic [WIDTH-1:0]                              ram_d_out,
  output logic [ADDR_WIDTH:0]                           rd_ptr,
  input  logic                                          flush,
  output logic [OUT_WIDTH-1:0]                          out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [ADDR_WIDTH+$clog2(WIDTH/OUT_WIDTH):0]   level
);

  localparam int RATIO      = WIDTH / OUT_WIDTH;
  localparam int RATIO_LOG2 = $clog2(RATIO);
  localparam int SIDX_W     = (RATIO > 1) ? RATIO_LOG2 : 1;
  localparam int LVL_W      = ADDR_WIDTH + 1 + RATIO_LOG2;
  localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(RATIO - 1);

  // Handshake: a slice moves on any rising edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that happens (flush/reset excepted).

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [SIDX_W-1:0]   sidx_q, sidx_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [ADDR_WIDTH:0] rd_q, rd_d;
  logic                empty;
  logic [OUT_WIDTH-1:0] slice;

  assign empty      = (wr_ptr == rd_q);
  assign rd_ptr     = rd_q;
  assign ram_addr_b = rd_q[ADDR_WIDTH-1:0];
  assign out_valid  = (state_q == HOLD);
  assign out_data   = (state_q == HOLD) ? slice : '0;

  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sidx_q == SIDX_W'(i)) slice = word_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    word_d  = word_q;
    rd_d    = rd_q;
    if (flush) begin
      rd_d    = wr_ptr;
      state_d = IDLE;
      sidx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            word_d  = ram_d_out;
            rd_d    = rd_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            sidx_d  = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (sidx_q != SIDX_LAST) begin
              sidx_d = sidx_q + SIDX_W'(1);
            end else if (!empty) begin
              // Last slice leaves and the next word lands on the same edge.
              word_d = ram_d_out;
              rd_d   = rd_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
              sidx_d = '0;
            end else begin
              sidx_d  = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sidx_q  <= '0;
      word_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      sidx_q  <= sidx_d;
      word_q  <= word_d;
      rd_q    <= rd_d;
    end
  end

`ifdef DIFF_FIFO_RD_LEVEL_EN
  logic [ADDR_WIDTH:0] words_d;
  logic [LVL_W-1:0]    level_d, level_q;

  assign words_d = wr_ptr - rd_d;

  // Registered from next-state values so it matches the outputs after the edge.
  always_comb begin
    level_d = LVL_W'(words_d) << RATIO_LOG2;
    if (state_d == HOLD) level_d = level_d + LVL_W'(RATIO) - LVL_W'(sidx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_diff_fifo_rd_port.sv
// Randomised bench for diff_fifo_rd_port: slice-queue reference model, per-cycle compare, directed literal checks.
module tb_diff_fifo_rd_port;

  localparam int WIDTH = 64;
  localparam int AW    = 6;
  localparam int OW    = 16;
  localparam int RATIO = WIDTH / OW;
  localparam int DEPTH = 1 << AW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW:0]       wr_ptr = '0;
  logic [AW-1:0]     ram_addr_b;
  logic [WIDTH-1:0]  ram_d_out;
  logic [AW:0]       rd_ptr;
  logic              flush = 1'b0;
  logic [OW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW+2:0]     level;

  logic [WIDTH-1:0]  mem [DEPTH];
  assign ram_d_out = mem[ram_addr_b];

  diff_fifo_rd_port #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr(wr_ptr), .ram_addr_b(ram_addr_b),
    .ram_d_out(ram_d_out), .rd_ptr(rd_ptr), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];
  int        held  = 0;      // slices left in the word the reader holds
  logic [AW:0] m_rd = '0;    // words handed out of RAM so far (mod 2^(AW+1))
  int        m_lvl = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  function automatic bit room();
    logic [AW:0] pend;
    pend = wr_ptr - m_rd;
    return int'(pend) < DEPTH;
  endfunction

  task automatic write_word(input logic [WIDTH-1:0] d);
    mem[wr_ptr[AW-1:0]] = d;
    for (int i = 0; i < RATIO; i++) exp_q.push_back(d[i*OW +: OW]);
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wr_ptr = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // reference model: a queue of every undelivered slice, advanced once per edge
  always @(posedge clk) begin
    logic [AW:0] pend;
    if (!rst_n) begin
      exp_q.delete();
      held  = 0;
      m_rd  = '0;
      m_lvl = 0;
    end else begin
      pend = wr_ptr - m_rd;
      if (flush) begin
        exp_q.delete();
        held = 0;
        m_rd = wr_ptr;
      end else begin
        if (held > 0 && out_ready) begin
          void'(exp_q.pop_front());
          held--;
        end
        if (held == 0 && pend != 0) begin
          held = RATIO;
          m_rd = m_rd + 1'b1;
        end
      end
      pend  = wr_ptr - m_rd;
      m_lvl = int'(pend) * RATIO + held;
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
    end else begin
      chk("valid", 64'(out_valid), 64'(held > 0));
      if (held > 0 && exp_q.size() > 0) chk("data", 64'(out_data), 64'(exp_q[0]));
      chk("rd_ptr", 64'(rd_ptr), 64'(m_rd));
      chk("ram_addr", 64'(ram_addr_b), 64'(m_rd[AW-1:0]));
`ifdef DIFF_FIFO_RD_LEVEL_EN
      chk("level", 64'(level), 64'(m_lvl));
`else
      chk("level", 64'(level), 64'd0);
`endif
    end
  end

  logic [OW-1:0] s_tab [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_rd_ptr", 64'(rd_ptr), 64'd0);
    rst_n = 1'b1;
    step();

    // single word, one-cycle latency, four slices then idle
    write_word(64'h4444_3333_2222_1111);
    out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_slice", 64'(out_data), 64'(s_tab[i]));
    end
    @(negedge clk);
    chk("single_end_valid", 64'(out_valid), 64'd0);
    chk("single_end_rd_ptr", 64'(rd_ptr), 64'd1);

    // back-pressure: three words preloaded, ready toggling
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_word({$urandom(), $urandom()});
      step();
    end
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_end_valid", 64'(out_valid), 64'd0);
    chk("bp_end_rd_ptr", 64'(rd_ptr), 64'd4);

    // flush at sidx=1 together with a transfer
    step();
    for (int i = 0; i < 5; i++) begin
      write_word({$urandom(), $urandom()});
      step();
    end
    out_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_rd_ptr", 64'(rd_ptr), 64'(wr_ptr));
    chk("flush_level", 64'(level), 64'd0);

    // level: two words pending
    do_reset();
    write_word(64'h0123_4567_89ab_cdef);
    write_word(64'hfedc_ba98_7654_3210);
    @(posedge clk);
    @(negedge clk);
`ifdef DIFF_FIFO_RD_LEVEL_EN
    chk("level_8", 64'(level), 64'd8);
`else
    chk("level_off", 64'(level), 64'd0);
`endif
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
`ifdef DIFF_FIFO_RD_LEVEL_EN
    chk("level_7", 64'(level), 64'd7);
`else
    chk("level_off", 64'(level), 64'd0);
`endif

    // asynchronous reset while holding a word at sidx=2
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    wr_ptr = '0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("async_rst_data", 64'(out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // wrap: 130 words streamed from reset
    step();
    out_ready = 1'b1;
    begin
      int written;
      written = 0;
      for (int c = 0; c < 700; c++) begin
        if (written < 130 && room()) begin
          write_word({$urandom(), $urandom()});
          written++;
        end
        step();
      end
    end
    @(negedge clk);
    chk("wrap_valid", 64'(out_valid), 64'd0);
    chk("wrap_rd_ptr", 64'(rd_ptr), 64'd2);

    // random traffic with occasional flush
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1 && room()) write_word({$urandom(), $urandom()});
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (300) step();
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_rd_ptr", 64'(rd_ptr), 64'(wr_ptr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
